intrapred_sched: RTL and testbench
==================================

# intrapred_sched

Scheduler for the intra-prediction datapath. Issues macroblock numbers for one frame into a five-stage pipeline: extract, mode-predict, residual, SAD, save. Tracks which macroblock occupies each stage and drives per-stage enables. Handles downstream backpressure, abort and end-of-frame signalling, and sits between the frame-level encoder control and the intra-prediction datapath instances.

## Interface
Parameters:
- MB_NUMBER_BITS, 12 — macroblock numbers are MB_NUMBER_BITS+1 bits wide, matching the datapath `mbnumber` port.

Ports:
- clk  in  1  — single clock.
- reset  in  1  — asynchronous, active-high.
- enable  in  1  — global advance qualifier; low freezes the whole pipeline.
- start  in  1  — one-cycle pulse; begins a frame. Ignored unless IDLE.
- abort  in  1  — synchronous flush; has priority over everything except reset.
- num_mbs  in  MB_NUMBER_BITS+1  — macroblocks in the frame; sampled on accepted start.
- out_ready  in  1  — save stage can accept; low stalls the whole pipeline.
- stage_en  out  5  — bit k: stage k performs work this cycle (0 = extract … 4 = save).
- stage_mb  out  5*(MB_NUMBER_BITS+1)  — packed, slice k = macroblock number held in stage k.
- busy  out  1  — high in RUN or DRAIN.
- done  out  1  — one-cycle pulse at frame completion.
- issued  out  MB_NUMBER_BITS+1  — count of macroblocks issued so far this frame.

## Operation
- State machine:
  - IDLE: start=1 → RUN.
  - RUN: issues one macroblock per advance cycle. Moves to DRAIN after issuing number num_mbs-1.
  - DRAIN: valid==0 → DONE.
  - DONE: one cycle, then → IDLE.
  - If num_mbs==0 on start, the FSM goes IDLE → DONE directly. No stage_en is asserted.
- Pipeline state:
  - valid[4:0] and mb[k] registers.
  - advance = enable & out_ready.
  - On advance: valid/mb shift from k to k+1. valid[0] = (state==RUN). mb[0] = issue counter, which then increments.
  - Without advance, all registers hold.
- Outputs:
  - stage_en[k] = valid[k] & advance (combinational).
  - stage_mb slice k = mb[k] (registered).
  - The save stage retires its macroblock on each cycle where stage_en[4]=1.
- abort in any state:
  - Next cycle: valid=0, counter=0, state=IDLE.
  - No done pulse is emitted.
  - A start in the same cycle as abort is ignored.
- Issue counter and num_mbs are unsigned. No wrap: issuing stops exactly at num_mbs-1.
- A start pulse while busy or in DONE is dropped, with no effect.
- Reset values of all outputs: stage_en=0, stage_mb=0, busy=0, done=0, issued=0. State is IDLE and valid is 0.

## Timing
- start is sampled at edge 0. From cycle 1, RUN and stage_en[0]=1 with stage_mb[0]=0, provided advance holds.
- Without stalls:
  - Macroblock n is in stage k during cycle 1+n+k.
  - The last macroblock retires in cycle num_mbs+4.
  - done pulses in cycle num_mbs+5 (DONE state). busy falls in the same cycle.
- A stall of S cycles (out_ready or enable low) delays every later event by exactly S. During a stall stage_en is 0 and stage_mb is unchanged.
- When advance is low on the cycle issuing would occur, the counter does not increment and issues no duplicate.
- If abort and stall occur together, abort wins.

## Structure
- Shared package intrapred_pkg holds:
  - NUM_STAGES = 5.
  - Stage index constants STG_EXT, STG_MOD, STG_RES, STG_SAD, STG_SAV.
  - The state enum sched_state_t {IDLE, RUN, DRAIN, DONE}.
- One natural sub-module, intrapred_stage_pipe: the valid/mb shift register with hold and flush inputs, parameterised on depth and tag width. The FSM and counter stay in intrapred_sched.

## Test plan
- num_mbs=3, enable=1, out_ready=1, start at cycle 0:
  - stage_en[0] high in cycles 1–3 with mb 0,1,2.
  - stage_en[4] high in cycles 5–7.
  - done in cycle 8.
  - issued=3.
- num_mbs=4, out_ready low for cycles 3–5 → no stage_en in cycles 3–5, stage_mb frozen, done in cycle 12.
- num_mbs=0 → done in cycle 1, stage_en never asserted, busy never high.
- num_mbs=8, abort in cycle 4 → cycle 5: valid all 0, busy=0, no done. A new start in cycle 6 (num_mbs=2) issues mb 0 in cycle 7.
- start re-pulsed in cycle 2 of a 5-macroblock frame → ignored; exactly 5 macroblocks retire, one done pulse.
- reset asserted asynchronously mid-frame (between edges) → all outputs 0 immediately. After release, start behaves as from power-up.

Source files
------------

// File: rtl/intrapred_pkg.sv
// rtl/intrapred_pkg.sv - shared constants and state type for the intra-prediction scheduler
package intrapred_pkg;
  localparam int NUM_STAGES = 5;

  localparam int STG_EXT = 0;
  localparam int STG_MOD = 1;
  localparam int STG_RES = 2;
  localparam int STG_SAD = 3;
  localparam int STG_SAV = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;
endpackage

// File: rtl/intrapred_stage_pipe.sv
// rtl/intrapred_stage_pipe.sv - valid/tag shift register with hold and flush
module intrapred_stage_pipe #(
  parameter int DEPTH = 5,
  parameter int TAG_W = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [DEPTH-1:0]       valid,
  output logic [DEPTH*TAG_W-1:0] tag
);

  // Flush only clears occupancy; stale tags are harmless once valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      tag   <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (shift) begin
      valid <= {valid[DEPTH-2:0], in_valid};
      tag   <= {tag[(DEPTH-1)*TAG_W-1:0], in_tag};
    end
  end

endmodule

// File: rtl/intrapred_sched.sv
// rtl/intrapred_sched.sv - issues macroblock numbers into the five-stage intra-prediction pipeline
module intrapred_sched
  import intrapred_pkg::*;
#(
  parameter int MB_NUMBER_BITS = 12
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [MB_NUMBER_BITS:0]                num_mbs,
  input  logic                                   out_ready,
  output logic [NUM_STAGES-1:0]                  stage_en,
  output logic [NUM_STAGES*(MB_NUMBER_BITS+1)-1:0] stage_mb,
  output logic                                   busy,
  output logic                                   done,
  output logic [MB_NUMBER_BITS:0]                issued
);

  localparam int MBW = MB_NUMBER_BITS + 1;
  localparam logic [MBW-1:0] ONE = MBW'(1);

  sched_state_t          state;
  logic [MBW-1:0]        num_mbs_q;
  logic [NUM_STAGES-1:0] valid;

  logic           advance;
  logic           start_ok;
  logic [MBW-1:0] eff_num;
  logic [MBW-1:0] base;
  logic           issue;
  logic           last_issue;

  // An accepted start issues macroblock 0 on the same edge, so the frame
  // length and counter base come from the inputs rather than the registers.
  always_comb begin
    advance    = enable & out_ready;
    start_ok   = (state == IDLE) & start;
    eff_num    = start_ok ? num_mbs : num_mbs_q;
    base       = start_ok ? '0 : issued;
    issue      = advance & ((state == RUN) | (start_ok & (num_mbs != '0)));
    last_issue = issue & (base == eff_num - ONE);
  end

  assign stage_en = valid & {NUM_STAGES{advance}};

  intrapred_stage_pipe #(
    .DEPTH (NUM_STAGES),
    .TAG_W (MBW)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .shift    (advance),
    .flush    (abort),
    .in_valid (issue),
    .in_tag   (base),
    .valid    (valid),
    .tag      (stage_mb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      issued    <= '0;
      num_mbs_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state  <= IDLE;
      issued <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_mbs_q <= num_mbs;
            issued    <= issue ? ONE : '0;
            if (num_mbs == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= last_issue ? DRAIN : RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issued <= issued + ONE;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish on the edge that shifts the last macroblock out of save.
          if (advance && valid[STG_SAD:STG_EXT] == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intrapred_sched.sv
// tb/tb_intrapred_sched.sv - randomized and directed bench for intrapred_sched against a frame-level model
module tb_intrapred_sched;
  localparam int MBB = 12;
  localparam int W   = MBB + 1;

  logic           clk = 1'b0;
  logic           reset, enable, start, abort, out_ready;
  logic [W-1:0]   num_mbs;
  logic [4:0]     stage_en;
  logic [5*W-1:0] stage_mb;
  logic           busy, done;
  logic [W-1:0]   issued;

  intrapred_sched #(.MB_NUMBER_BITS(MBB)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .abort     (abort),
    .num_mbs   (num_mbs),
    .out_ready (out_ready),
    .stage_en  (stage_en),
    .stage_mb  (stage_mb),
    .busy      (busy),
    .done      (done),
    .issued    (issued)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: slot[k] is the macroblock in stage k, -1 when empty.
  int slot[5];
  int next_mb, total;
  bit frame_on, done_now;
  int cyc_n, start_at, done_at, done_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) slot[k] = -1;
    next_mb  = 0;
    total    = 0;
    frame_on = 1'b0;
    done_now = 1'b0;
  endtask

  task automatic cycle(input bit st, input bit ab, input bit en, input bit rdy, input int num);
    bit adv, dn, empty;
    adv       = en && rdy;
    start     = st;
    abort     = ab;
    enable    = en;
    out_ready = rdy;
    num_mbs   = num[W-1:0];
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stage_en[%0d] c%0d", k, cyc_n), 64'(stage_en[k]), 64'(slot[k] >= 0 && adv));
      if (slot[k] >= 0)
        check($sformatf("stage_mb[%0d] c%0d", k, cyc_n), 64'(stage_mb[k*W +: W]), 64'(slot[k]));
    end
    check($sformatf("busy c%0d", cyc_n), 64'(busy), 64'(frame_on));
    check($sformatf("done c%0d", cyc_n), 64'(done), 64'(done_now));
    check($sformatf("issued c%0d", cyc_n), 64'(issued), 64'(next_mb));
    if (done === 1'b1) begin
      done_at = cyc_n;
      done_cnt++;
    end
    if (st) start_at = cyc_n;
    @(posedge clk);
    #1;
    cyc_n++;
    if (ab) begin
      model_reset();
      total = total;
    end else begin
      dn = 1'b0;
      if (!frame_on && !done_now && st) begin
        total   = num;
        next_mb = 0;
        if (num == 0) dn = 1'b1;
        else frame_on = 1'b1;
      end
      if (adv) begin
        for (int k = 4; k > 0; k--) slot[k] = slot[k-1];
        if (frame_on && next_mb < total) begin
          slot[0] = next_mb;
          next_mb++;
        end else begin
          slot[0] = -1;
        end
        empty = 1'b1;
        for (int k = 0; k < 5; k++) if (slot[k] >= 0) empty = 1'b0;
        if (frame_on && next_mb == total && empty) begin
          frame_on = 1'b0;
          dn = 1'b1;
        end
      end
      done_now = dn;
    end
  endtask

  task automatic clear_marks();
    done_at  = -1;
    done_cnt = 0;
    start_at = -1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);
  endtask

  task automatic basic_frame3();
    int s;
    clear_marks();
    s = cyc_n;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 3);
    idle_cycles(10);
    check("frame3 done cycle", 64'(done_at - s), 64'd8);
    check("frame3 done count", 64'(done_cnt), 64'd1);
    check("frame3 issued", 64'(issued), 64'd3);
  endtask

  initial begin
    int s, first;
    reset = 1'b1; enable = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; num_mbs = '0;
    model_reset();
    cyc_n = 0;
    clear_marks();
    repeat (2) @(posedge clk);
    #1;
    check("reset stage_en", 64'(stage_en), 64'd0);
    check("reset stage_mb", 64'(stage_mb), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset issued", 64'(issued), 64'd0);
    reset = 1'b0;

    basic_frame3();

    // Backpressure on cycles 3..5 of a four-macroblock frame.
    clear_marks();
    s = cyc_n;
    for (int c = 0; c < 16; c++) cycle(c == 0, 1'b0, 1'b1, !(c >= 3 && c <= 5), 4);
    check("stall done cycle", 64'(done_at - s), 64'd12);

    // Empty frame.
    clear_marks();
    s = cyc_n;
    for (int c = 0; c < 4; c++) cycle(c == 0, 1'b0, 1'b1, 1'b1, 0);
    check("empty done cycle", 64'(done_at - s), 64'd1);
    check("empty done count", 64'(done_cnt), 64'd1);

    // Abort mid-frame, then restart.
    clear_marks();
    s = cyc_n;
    for (int c = 0; c < 16; c++) begin
      if (c == 5) check("abort no done", 64'(done_cnt), 64'd0);
      cycle(c == 0 || c == 6, c == 4, 1'b1, 1'b1, (c == 6) ? 2 : 8);
    end
    check("abort restart done cycle", 64'(done_at - s), 64'd13);
    check("abort restart done count", 64'(done_cnt), 64'd1);

    // Start re-pulsed while busy is dropped.
    clear_marks();
    s = cyc_n;
    for (int c = 0; c < 14; c++) cycle(c == 0 || c == 2, 1'b0, 1'b1, 1'b1, 5);
    check("repulse done cycle", 64'(done_at - s), 64'd10);
    check("repulse done count", 64'(done_cnt), 64'd1);
    check("repulse issued", 64'(issued), 64'd5);

    // Asynchronous reset between edges while a frame is in flight.
    for (int c = 0; c < 4; c++) cycle(c == 0, 1'b0, 1'b1, 1'b1, 6);
    #2;
    reset = 1'b1;
    #1;
    check("async reset stage_en", 64'(stage_en), 64'd0);
    check("async reset stage_mb", 64'(stage_mb), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset issued", 64'(issued), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    basic_frame3();

    // Randomized traffic.
    clear_marks();
    first = cyc_n;
    for (int i = 0; i < 800; i++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 5));
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, n);
    end
    check("random cycles elapsed", 64'(cyc_n - first), 64'd800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
